bitwise_checker: RTL and testbench

Streaming checker for the 7-lane bitwise operator unit. It consumes one sample per handshake, where a sample is operands A[6:0] and B[5:0] plus the unit's result Y[6:0]. It recomputes the expected per-lane result and reports mismatches per sample, and it keeps sticky per-lane error flags, saturating counters and a first-failure capture. It sits between the operator unit and the self-test/status logic as the verifying end of that datapath.

---
 rtl/bitwise_checker.sv | 146 ++++++++++++++
 tb/tb_bitwise_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_checker.sv
// rtl/bitwise_checker.sv - streaming checker for the 7-lane bitwise operator unit
module bitwise_checker #(
    parameter int CNT_W       = 16,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_a,
    input  logic [5:0]       in_b,
    input  logic [6:0]       in_y,
    output logic             chk_valid,
    output logic [6:0]       chk_mask,
    output logic [6:0]       err_sticky,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [6:0]       fail_a,
    output logic [5:0]       fail_b,
    output logic [6:0]       fail_y,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     cur_state;
    state_t     nxt_state;

    logic       s1_valid;
    logic [6:0] s1_a;
    logic [5:0] s1_b;
    logic [6:0] s1_y;
    logic [6:0] s1_exp;
    logic [6:0] s1_mask;
    logic       s1_fail;
    logic       accept;

    assign state  = cur_state;
    assign accept = in_valid & in_ready;

    // Reference model of the operator unit, one gate per lane.
    always_comb begin
        s1_exp[0] = s1_a[0] & s1_b[0];
        s1_exp[1] = s1_a[1] | s1_b[1];
        s1_exp[2] = ~(s1_a[2] & s1_b[2]);
        s1_exp[3] = ~(s1_a[3] | s1_b[3]);
        s1_exp[4] = s1_a[4] ^ s1_b[4];
        s1_exp[5] = ~(s1_a[5] ^ s1_b[5]);
        s1_exp[6] = ~s1_a[6];
    end

    assign s1_mask = s1_exp ^ s1_y;
    assign s1_fail = s1_valid & (|s1_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Decision order: clear, stop, start, then the halt-on-error transition.
    always_comb begin
        nxt_state = cur_state;
        if (clear) begin
            nxt_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (stop)
                        nxt_state = ST_IDLE;
                    else if (start)
                        nxt_state = ST_RUN;
                end
                ST_RUN: begin
                    if (stop)
                        nxt_state = ST_IDLE;
                    else if (start)
                        nxt_state = ST_RUN;
                    else if (HALT_ON_ERR && s1_fail)
                        nxt_state = ST_HALT;
                end
                ST_HALT: nxt_state = ST_HALT;
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (cur_state == ST_RUN);
    end

    // Stage 1 holds the accepted sample; stage 2 and all status update from it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_y       <= '0;
            chk_valid  <= 1'b0;
            chk_mask   <= '0;
            err_sticky <= '0;
            smp_cnt    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_y     <= '0;
        end else begin
            s1_valid  <= accept;
            if (accept) begin
                s1_a <= in_a;
                s1_b <= in_b;
                s1_y <= in_y;
            end
            chk_valid <= s1_valid;
            if (s1_valid) begin
                chk_mask   <= s1_mask;
                err_sticky <= err_sticky | s1_mask;
                if (smp_cnt != CNT_MAX)
                    smp_cnt <= smp_cnt + CNT_ONE;
                if ((|s1_mask) && (err_cnt != CNT_MAX))
                    err_cnt <= err_cnt + CNT_ONE;
                if ((|s1_mask) && !fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_a     <= s1_a;
                    fail_b     <= s1_b;
                    fail_y     <= s1_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitwise_checker.sv
// tb/tb_bitwise_checker.sv - directed self-checking bench for bitwise_checker
module tb_bitwise_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic       in_valid;
    logic [6:0] in_a;
    logic [5:0] in_b;
    logic [6:0] in_y;

    logic        d_in_ready, d_chk_valid, d_fail_valid;
    logic [6:0]  d_chk_mask, d_err_sticky, d_fail_a, d_fail_y;
    logic [5:0]  d_fail_b;
    logic [15:0] d_smp_cnt, d_err_cnt;
    logic [1:0]  d_state;

    logic        h_in_ready, h_chk_valid, h_fail_valid;
    logic [6:0]  h_chk_mask, h_err_sticky, h_fail_a, h_fail_y;
    logic [5:0]  h_fail_b;
    logic [15:0] h_smp_cnt, h_err_cnt;
    logic [1:0]  h_state;

    logic        s_in_ready, s_chk_valid, s_fail_valid;
    logic [6:0]  s_chk_mask, s_err_sticky, s_fail_a, s_fail_y;
    logic [5:0]  s_fail_b;
    logic [3:0]  s_smp_cnt, s_err_cnt;
    logic [1:0]  s_state;

    int checks;
    int errors;

    bitwise_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .in_valid(in_valid), .in_ready(d_in_ready),
        .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .chk_valid(d_chk_valid), .chk_mask(d_chk_mask), .err_sticky(d_err_sticky),
        .smp_cnt(d_smp_cnt), .err_cnt(d_err_cnt), .fail_valid(d_fail_valid),
        .fail_a(d_fail_a), .fail_b(d_fail_b), .fail_y(d_fail_y), .state(d_state)
    );

    bitwise_checker #(.CNT_W(16), .HALT_ON_ERR(1'b1)) u_halt (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .in_valid(in_valid), .in_ready(h_in_ready),
        .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .chk_valid(h_chk_valid), .chk_mask(h_chk_mask), .err_sticky(h_err_sticky),
        .smp_cnt(h_smp_cnt), .err_cnt(h_err_cnt), .fail_valid(h_fail_valid),
        .fail_a(h_fail_a), .fail_b(h_fail_b), .fail_y(h_fail_y), .state(h_state)
    );

    bitwise_checker #(.CNT_W(4), .HALT_ON_ERR(1'b0)) u_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .chk_valid(s_chk_valid), .chk_mask(s_chk_mask), .err_sticky(s_err_sticky),
        .smp_cnt(s_smp_cnt), .err_cnt(s_err_cnt), .fail_valid(s_fail_valid),
        .fail_a(s_fail_a), .fail_b(s_fail_b), .fail_y(s_fail_y), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_y(input logic [6:0] a, input logic [5:0] b);
        logic [6:0] r;
        r[0] = a[0] & b[0];
        r[1] = a[1] | b[1];
        r[2] = !(a[2] & b[2]);
        r[3] = !(a[3] | b[3]);
        r[4] = a[4] != b[4];
        r[5] = a[5] == b[5];
        r[6] = !a[6];
        return r;
    endfunction

    initial begin
        logic [6:0] keep_a;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_y     = '0;
        keep_a   = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_state", d_state, 2'b00);
        check("rst_ready", d_in_ready, 1'b0);
        check("rst_chk_valid", d_chk_valid, 1'b0);
        check("rst_smp_cnt", d_smp_cnt, 16'h0);
        check("rst_fail_valid", d_fail_valid, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_state", d_state, 2'b01);
        check("run_ready", d_in_ready, 1'b1);

        // Good sample a=00 b=00 y=6C
        in_valid = 1'b1; in_a = 7'h00; in_b = 6'h00; in_y = 7'h6C;
        tick();
        in_valid = 1'b0;
        check("good_lat1", d_chk_valid, 1'b0);
        tick();
        check("good_valid", d_chk_valid, 1'b1);
        check("good_mask", d_chk_mask, 7'h00);
        check("good_smp", d_smp_cnt, 16'd1);
        check("good_err", d_err_cnt, 16'd0);
        tick();
        check("good_pulse", d_chk_valid, 1'b0);

        // Lane 0 flipped: expected 23, presented 22
        in_valid = 1'b1; in_a = 7'h7F; in_b = 6'h3F; in_y = 7'h22;
        tick();
        in_valid = 1'b0;
        tick();
        check("bad_valid", d_chk_valid, 1'b1);
        check("bad_mask", d_chk_mask, 7'h01);
        check("bad_err", d_err_cnt, 16'd1);
        check("bad_smp", d_smp_cnt, 16'd2);
        check("bad_sticky", d_err_sticky, 7'h01);
        check("bad_fail_valid", d_fail_valid, 1'b1);
        check("bad_fail_y", d_fail_y, 7'h22);
        check("bad_fail_a", d_fail_a, 7'h7F);
        check("bad_fail_b", d_fail_b, 6'h3F);
        check("halt_after_bad", h_state, 2'b10);

        // Second failure on lane 4 must not overwrite the capture
        in_valid = 1'b1; in_a = 7'h00; in_b = 6'h00; in_y = 7'h7C;
        tick();
        in_valid = 1'b0;
        tick();
        check("bad2_mask", d_chk_mask, 7'h10);
        check("bad2_sticky", d_err_sticky, 7'h11);
        check("bad2_err", d_err_cnt, 16'd2);
        check("bad2_fail_y", d_fail_y, 7'h22);
        check("bad2_fail_a", d_fail_a, 7'h7F);

        // Halt-on-error stream, failing sample at index 3
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_h_state", h_state, 2'b00);
        check("clr_h_smp", h_smp_cnt, 16'd0);
        check("clr_h_fail_valid", h_fail_valid, 1'b0);
        check("clr_d_sticky", d_err_sticky, 7'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = 7'(i * 13 + 5);
            in_b = 6'(i * 7 + 3);
            in_y = ref_y(in_a, in_b) ^ ((i == 3) ? 7'h04 : 7'h00);
            if (i == 3)
                keep_a = in_a;
            tick();
            if (i == 3)
                check("halt_not_yet", h_state, 2'b01);
            if (i == 4) begin
                check("halt_state", h_state, 2'b10);
                check("halt_ready", h_in_ready, 1'b0);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("halt_smp", h_smp_cnt, 16'd5);
        check("halt_err", h_err_cnt, 16'd1);
        check("halt_sticky", h_err_sticky, 7'h04);
        check("halt_fail_a", h_fail_a, keep_a);
        check("halt_ready_hold", h_in_ready, 1'b0);
        check("halt_state_hold", h_state, 2'b10);
        check("nohalt_smp", d_smp_cnt, 16'd6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("hclr_state", h_state, 2'b00);
        check("hclr_smp", h_smp_cnt, 16'd0);
        check("hclr_err", h_err_cnt, 16'd0);
        check("hclr_sticky", h_err_sticky, 7'h00);
        check("hclr_fail_valid", h_fail_valid, 1'b0);
        check("hclr_fail_y", h_fail_y, 7'h00);
        check("hclr_mask", h_chk_mask, 7'h00);

        // Saturation with CNT_W=4
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_a = 7'(i * 29 + 1);
            in_b = 6'(i * 11 + 2);
            in_y = ref_y(in_a, in_b);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_smp", s_smp_cnt, 4'hF);
        check("sat_err", s_err_cnt, 4'h0);
        check("wide_smp", d_smp_cnt, 16'd20);

        // Clear with samples in flight
        in_valid = 1'b1; in_a = 7'h55; in_b = 6'h2A; in_y = 7'h00;
        tick();
        in_a = 7'h12; in_b = 6'h34; in_y = 7'h7F;
        tick();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("fclr_state", d_state, 2'b00);
        check("fclr_smp", d_smp_cnt, 16'd0);
        check("fclr_err", d_err_cnt, 16'd0);
        check("fclr_fail_valid", d_fail_valid, 1'b0);
        check("fclr_sticky", d_err_sticky, 7'h00);
        for (int i = 0; i < 3; i++) begin
            check("fclr_no_valid", d_chk_valid, 1'b0);
            tick();
        end
        check("fclr_smp_after", d_smp_cnt, 16'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_state", d_state, 2'b00);
        check("ss_ready", d_in_ready, 1'b0);

        // stop with continuous in_valid; sample at the stop edge fails on lane 6
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = 7'(i * 17 + 9);
            in_b = 6'(i * 5 + 1);
            in_y = ref_y(in_a, in_b) ^ ((i == 3) ? 7'h40 : 7'h00);
            if (i == 3) begin
                stop   = 1'b1;
                keep_a = in_a;
            end
            tick();
        end
        stop = 1'b0;
        in_a = 7'h01; in_b = 6'h01; in_y = 7'h00;
        check("stop_state", d_state, 2'b00);
        check("stop_ready", d_in_ready, 1'b0);
        tick();
        check("stop_last_valid", d_chk_valid, 1'b1);
        check("stop_last_mask", d_chk_mask, 7'h40);
        tick();
        tick();
        in_valid = 1'b0;
        check("stop_smp", d_smp_cnt, 16'd4);
        check("stop_err", d_err_cnt, 16'd1);
        check("stop_sticky", d_err_sticky, 7'h40);
        check("stop_fail_a", d_fail_a, keep_a);
        check("stop_idle_valid", d_chk_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
